// File: rtl/mem_pkg.sv
// Shared types for the memory responder: FSM states, request source tags, word mask.
package mem_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} mem_state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_I, SRC_DR, SRC_DW} mem_src_t;

  localparam logic [1:0] WORD_MASK = 2'b11;

endpackage

// File: rtl/mem_lat_counter.sv
// RAM access latency down-counter: load to RAM_LATENCY-1, decrement, terminal-count flag.
module mem_lat_counter #(
  parameter int RAM_LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = $clog2(RAM_LATENCY) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(RAM_LATENCY - 1);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_responder.sv
// Arbitrates instruction fetches and data loads/stores onto one fixed-latency single-port RAM.
// Optional MEM_ALIGN_CHECK_EN: misaligned requests skip the RAM and pulse d_err with ready.
//
// state  | meaning
// IDLE   | waiting for a request; data wins over instruction, store over load
// ACCESS | RAM strobe held while the latency counter runs down
// DONE   | ready pulse cycle; requests ignored
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RAM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_ren,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_load,
  output logic              i_ready,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_store,
  output logic [DATA_W-1:0] d_load,
  output logic              d_ready,
  output logic              d_err,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_store,
  output logic              ram_ren,
  output logic              ram_wen,
  input  logic [DATA_W-1:0] ram_load
);

  mem_state_t        state;
  mem_src_t          src;
  mem_src_t          req_src;
  logic [ADDR_W-1:0] req_addr;
  logic              req_any;
  logic              misalign;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_zero;

  always_comb begin
    req_src  = SRC_NONE;
    req_addr = i_addr;
    if (d_wen) begin
      req_src  = SRC_DW;
      req_addr = d_addr;
    end else if (d_ren) begin
      req_src  = SRC_DR;
      req_addr = d_addr;
    end else if (i_ren) begin
      req_src  = SRC_I;
    end
  end

  assign req_any = (req_src != SRC_NONE);

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = |(req_addr[1:0] & WORD_MASK);
`else
  assign misalign = 1'b0;
`endif

  assign cnt_load = (state == IDLE) && req_any && !misalign;
  assign cnt_dec  = (state == ACCESS);
  assign busy     = (state != IDLE);

  mem_lat_counter #(.RAM_LATENCY(RAM_LATENCY)) u_lat (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .zero (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      src       <= SRC_NONE;
      i_load    <= '0;
      i_ready   <= 1'b0;
      d_load    <= '0;
      d_ready   <= 1'b0;
      d_err     <= 1'b0;
      ram_addr  <= '0;
      ram_store <= '0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      d_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            src <= req_src;
            if (misalign) begin
              state <= DONE;
              d_err <= 1'b1;
              if (req_src == SRC_I) i_ready <= 1'b1;
              else                  d_ready <= 1'b1;
            end else begin
              state     <= ACCESS;
              ram_addr  <= req_addr & ~ADDR_W'(WORD_MASK);
              ram_store <= (req_src == SRC_DW) ? d_store : '0;
              ram_ren   <= (req_src != SRC_DW);
              ram_wen   <= (req_src == SRC_DW);
            end
          end
        end
        ACCESS: begin
          if (cnt_zero) begin
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            state   <= DONE;
            case (src)
              SRC_I:   begin i_load <= ram_load; i_ready <= 1'b1; end
              SRC_DR:  begin d_load <= ram_load; d_ready <= 1'b1; end
              default: d_ready <= 1'b1;
            endcase
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed cases then randomized concurrent requesters.
module tb_mem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_ren = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_load;
  logic        i_ready;
  logic        d_ren = 1'b0;
  logic        d_wen = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_store = '0;
  logic [31:0] d_load;
  logic        d_ready;
  logic        d_err;
  logic        busy;
  logic [31:0] ram_addr;
  logic [31:0] ram_store;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_load;

  mem_responder dut (
    .clk(clk), .rst(rst),
    .i_ren(i_ren), .i_addr(i_addr), .i_load(i_load), .i_ready(i_ready),
    .d_ren(d_ren), .d_wen(d_wen), .d_addr(d_addr), .d_store(d_store),
    .d_load(d_load), .d_ready(d_ready), .d_err(d_err), .busy(busy),
    .ram_addr(ram_addr), .ram_store(ram_store), .ram_ren(ram_ren), .ram_wen(ram_wen),
    .ram_load(ram_load)
  );

  always #5 clk = ~clk;

  // RAM environment (sync read, one cycle) and independent reference memory
  logic [31:0] ram [0:2047];
  logic [31:0] mdl [0:2047];

  always @(posedge clk) begin
    if (ram_wen) ram[ram_addr[12:2]] = ram_store;
    if (ram_ren) ram_load <= ram[ram_addr[12:2]];
  end

  function automatic logic [31:0] init_word(int w);
    return (32'(w) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit is_mis(logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
    return (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  typedef struct {
    int          kind;   // 0 fetch, 1 load, 2 store
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] dold;
    bit          mis;
  } txn_t;

  txn_t iq[$];
  txn_t dq[$];
  logic [31:0] ilast = '0;
  logic [31:0] dlast = '0;

  int errors = 0;
  int checks = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: protocol checks each cycle, scoreboard pops on ready
  int          run = 0;
  logic [31:0] s_addr = '0;
  logic [31:0] s_store = '0;
  logic        s_wen = 1'b0;

  always @(negedge clk) begin
    txn_t t;
    if (rst) begin
      run = 0;
    end else begin
      check("busy", 32'(busy), 32'(ram_ren | ram_wen | i_ready | d_ready));
      check("strobe_excl", 32'(ram_ren & ram_wen), 0);
      check("ready_excl", 32'(i_ready & d_ready), 0);
      if (!i_ready && !d_ready) check("derr_idle", 32'(d_err), 0);
      if (i_ready) begin
        if (iq.size() == 0) begin
          check("i_ready_spurious", 32'(i_ready), 0);
        end else begin
          t = iq.pop_front();
          check("i_load", i_load, t.data);
          check("i_strobe_len", 32'(run), t.mis ? 0 : LAT);
          check("i_err", 32'(d_err), 32'(t.mis));
          if (!t.mis) begin
            check("i_ram_addr", s_addr, t.addr & ~32'h3);
            check("i_strobe_kind", 32'(s_wen), 0);
          end
        end
        run = 0;
      end
      if (d_ready) begin
        if (dq.size() == 0) begin
          check("d_ready_spurious", 32'(d_ready), 0);
        end else begin
          t = dq.pop_front();
          check("d_strobe_len", 32'(run), t.mis ? 0 : LAT);
          check("d_err", 32'(d_err), 32'(t.mis));
          if (t.kind == 2) begin
            check("d_load_hold", d_load, t.dold);
            if (!t.mis) begin
              check("st_ram_addr", s_addr, t.addr & ~32'h3);
              check("st_kind", 32'(s_wen), 1);
              check("st_data", s_store, t.data);
            end
          end else begin
            check("d_load", d_load, t.data);
            if (!t.mis) begin
              check("ld_ram_addr", s_addr, t.addr & ~32'h3);
              check("ld_kind", 32'(s_wen), 0);
            end
          end
        end
        run = 0;
      end
      if (ram_ren || ram_wen) begin
        if (run > 0) begin
          check("addr_stable", ram_addr, s_addr);
          check("store_stable", ram_store, s_store);
        end
        run++;
        s_addr  = ram_addr;
        s_wen   = ram_wen;
        s_store = ram_store;
      end
    end
  end

  task automatic wait_rdy(input bit dside, input string nm);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(dside ? d_ready : i_ready) && n < 40);
    if (!(dside ? d_ready : i_ready)) check(nm, 32'(dside ? d_ready : i_ready), 1);
  endtask

  task automatic fetch(input logic [31:0] a);
    txn_t t;
    t.kind = 0; t.addr = a; t.mis = is_mis(a); t.dold = '0;
    t.data = t.mis ? ilast : mdl[a[12:2]];
    ilast = t.data;
    iq.push_back(t);
    i_addr = a;
    i_ren  = 1'b1;
    wait_rdy(1'b0, "i_ready_timeout");
    i_ren  = 1'b0;
  endtask

  task automatic data_op(input int kind, input logic [31:0] a, input logic [31:0] wd, input bit both);
    txn_t t;
    t.kind = kind; t.addr = a; t.mis = is_mis(a); t.dold = dlast;
    if (kind == 2) begin
      t.data = wd;
      if (!t.mis) mdl[a[12:2]] = wd;
    end else begin
      t.data = t.mis ? dlast : mdl[a[12:2]];
      dlast  = t.data;
    end
    dq.push_back(t);
    d_addr  = a;
    d_store = wd;
    d_wen   = (kind == 2);
    d_ren   = (kind == 1) || both;
    wait_rdy(1'b1, "d_ready_timeout");
    d_wen = 1'b0;
    d_ren = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int td, ti, cyc;
    for (int w = 0; w < 2048; w++) begin
      ram[w] = init_word(w);
      mdl[w] = init_word(w);
    end
    ram[32'h40 >> 2] = 32'hDEAD_BEEF;
    mdl[32'h40 >> 2] = 32'hDEAD_BEEF;

    // Reset with a fetch pending
    i_ren = 1'b1; i_addr = 32'h40;
    repeat (3) @(posedge clk);
    #1;
    check("rst_i_load", i_load, 0);
    check("rst_i_ready", 32'(i_ready), 0);
    check("rst_d_load", d_load, 0);
    check("rst_d_ready", 32'(d_ready), 0);
    check("rst_d_err", 32'(d_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_store", ram_store, 0);
    check("rst_ram_ren", 32'(ram_ren), 0);
    check("rst_ram_wen", 32'(ram_wen), 0);
    i_ren = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed fetch with cycle-exact timing
    iq.push_back('{kind: 0, addr: 32'h40, data: 32'hDEAD_BEEF, dold: 0, mis: 1'b0});
    ilast = 32'hDEAD_BEEF;
    i_addr = 32'h40; i_ren = 1'b1;
    @(posedge clk); #1;
    check("f_ren_c1", 32'(ram_ren), 1);
    check("f_addr_c1", ram_addr, 32'h40);
    @(posedge clk); #1;
    check("f_ren_c2", 32'(ram_ren), 1);
    check("f_rdy_c2", 32'(i_ready), 0);
    @(posedge clk); #1;
    check("f_ren_c3", 32'(ram_ren), 0);
    check("f_rdy_c3", 32'(i_ready), 1);
    check("f_load_c3", i_load, 32'hDEAD_BEEF);
    i_ren = 1'b0;
    @(posedge clk); #1;
    check("f_rdy_c4", 32'(i_ready), 0);
    check("f_busy_c4", 32'(busy), 0);

    // Collision: data first, fetch LAT+2 cycles later
    begin
      txn_t t;
      t.kind = 1; t.addr = 32'h100; t.mis = 1'b0; t.dold = dlast; t.data = mdl[32'h100 >> 2];
      dlast = t.data; dq.push_back(t);
      t.kind = 0; t.addr = 32'h44; t.dold = 0; t.data = mdl[32'h44 >> 2];
      ilast = t.data; iq.push_back(t);
    end
    d_addr = 32'h100; d_ren = 1'b1; i_addr = 32'h44; i_ren = 1'b1;
    td = -1; ti = -1; cyc = 0;
    while ((td < 0 || ti < 0) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (d_ready) begin td = cyc; d_ren = 1'b0; end
      if (i_ready) begin ti = cyc; i_ren = 1'b0; end
    end
    d_ren = 1'b0; i_ren = 1'b0;
    check("coll_order_gap", 32'(ti - td), LAT + 2);

    // Store then read back
    data_op(2, 32'h104, 32'h1234_5678, 1'b0);
    data_op(1, 32'h104, 32'h0, 1'b0);

    // Abort in second ACCESS cycle
    i_addr = 32'h80; i_ren = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; i_ren = 1'b0;
    @(posedge clk); #1;
    check("abort_ren", 32'(ram_ren), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_i_ready", 32'(i_ready), 0);
    check("abort_i_load", i_load, 0);
    check("abort_d_load", d_load, 0);
    rst = 1'b0; ilast = '0; dlast = '0;
    repeat (3) @(posedge clk);
    #1;

    // Misaligned accesses
    data_op(1, 32'h102, 32'h0, 1'b0);
    fetch(32'h46);
    data_op(2, 32'h10A, 32'hCAFE_F00D, 1'b0);
    data_op(1, 32'h108, 32'h0, 1'b0);

    // Random concurrent traffic
    fork
      begin
        for (int n = 0; n < 25; n++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          fetch(32'($urandom_range(0, 255)) << 2);
        end
      end
      begin
        for (int n = 0; n < 35; n++) begin
          int k;
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          k = $urandom_range(0, 2);
          data_op((k == 0) ? 1 : 2, 32'h1000 + (32'($urandom_range(0, 15)) << 2), $urandom, (k == 2));
        end
      end
    join

    repeat (5) @(posedge clk);
    #1;
    check("iq_drained", 32'(iq.size()), 0);
    check("dq_drained", 32'(dq.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
